// File: rtl/multi_task_sequencer.sv
// multi_task_sequencer: per-channel start/done task sequencer with a bounded request queue.
// Define TASK_TIMEOUT_EN to build a per-channel RUN watchdog that aborts after TIMEOUT_CYCLES.
module multi_task_sequencer #(
    parameter int CHANNELS       = 4,
    parameter int DEPTH          = 3,
    parameter int CNT_WIDTH      = $clog2(DEPTH + 1),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [CHANNELS-1:0]           FLAG_IN,
    input  logic [CHANNELS-1:0]           TASK_DONE_IN,
    input  logic                          CLEAR,
    output logic [CHANNELS-1:0]           FLAG_OUT,
    output logic [CHANNELS-1:0]           BUSY,
    output logic [CHANNELS-1:0]           TASK_DONE_OUT,
    output logic [CHANNELS-1:0]           TIMEOUT,
    output logic [CHANNELS-1:0]           OVERFLOW,
    output logic [CHANNELS*CNT_WIDTH-1:0] PENDING
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            state_t               state, state_nx;
            logic [CNT_WIDTH-1:0] pend, pend_nx;
            logic                 ovf, ovf_nx, start, start_nx, tmo, tmo_nx;
            logic                 expire, busy, done_out, tmo_out;
`ifdef TASK_TIMEOUT_EN
            localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
            logic [TW-1:0] wd;
            always_ff @(posedge CLK or negedge RST_N)
                if (!RST_N) wd <= '0;
                else        wd <= (state == RUN) ? wd + 1'b1 : '0;
            assign expire = (state == RUN) && (wd == TW'(TIMEOUT_CYCLES - 1));
`else
            assign expire = TIMEOUT_CYCLES < 0;
`endif
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    state <= IDLE;
                    pend  <= '0;
                    ovf   <= 1'b0;
                    start <= 1'b0;
                    tmo   <= 1'b0;
                end else begin
                    state <= state_nx;
                    pend  <= pend_nx;
                    ovf   <= ovf_nx;
                    start <= start_nx;
                    tmo   <= tmo_nx;
                end
            end
            always_comb begin
                state_nx = state;
                pend_nx  = pend;
                start_nx = 1'b0;
                tmo_nx   = 1'b0;
                ovf_nx   = CLEAR ? 1'b0 : ovf;
                case (state)
                    IDLE: begin
                        state_nx = FLAG_IN[i] ? RUN : IDLE;
                        start_nx = FLAG_IN[i];
                    end
                    RUN: begin
                        state_nx = (TASK_DONE_IN[i] || expire) ? DONE : RUN;
                        tmo_nx   = !TASK_DONE_IN[i] && expire;
                        if (FLAG_IN[i] && pend == CNT_WIDTH'(DEPTH)) ovf_nx = 1'b1;
                        else if (FLAG_IN[i])                          pend_nx = pend + 1'b1;
                    end
                    DONE: begin
                        // a flag arriving with work queued nets out against the request being consumed
                        state_nx = (pend != '0 || FLAG_IN[i]) ? RUN : IDLE;
                        start_nx = pend != '0 || FLAG_IN[i];
                        pend_nx  = (pend != '0 && !FLAG_IN[i]) ? pend - 1'b1 : pend;
                    end
                    default: state_nx = IDLE;
                endcase
            end
            always_comb begin
                busy     = state == RUN;
                done_out = state == DONE && !tmo;
                tmo_out  = state == DONE && tmo;
            end
            assign FLAG_OUT[i]                        = start;
            assign BUSY[i]                            = busy;
            assign TASK_DONE_OUT[i]                   = done_out;
            assign TIMEOUT[i]                         = tmo_out;
            assign OVERFLOW[i]                        = ovf;
            assign PENDING[i*CNT_WIDTH +: CNT_WIDTH]  = pend;
        end
    endgenerate
endmodule

// File: tb/tb_multi_task_sequencer.sv
// tb_multi_task_sequencer: randomized and directed checks against a per-channel behavioural model.
module tb_multi_task_sequencer;
    localparam int CH = 4, DEPTH = 3, CW = $clog2(DEPTH + 1), TMO = 8;
    localparam int AW = 5 * CH + CH * CW;
`ifdef TASK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic CLK = 1'b0, RST_N = 1'b0, CLEAR = 1'b0;
    logic [CH-1:0] FLAG_IN = '0, TASK_DONE_IN = '0;
    logic [CH-1:0] FLAG_OUT, BUSY, TASK_DONE_OUT, TIMEOUT, OVERFLOW;
    logic [CH*CW-1:0] PENDING;
    logic [AW-1:0] obs;
    int total = 0, bad = 0;
    bit m_run[CH], m_ovf[CH];
    int m_age[CH], m_pend[CH];
    logic [CH-1:0] e_fo, e_tdo, e_tmo;

    multi_task_sequencer #(.CHANNELS(CH), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLAG_IN(FLAG_IN), .TASK_DONE_IN(TASK_DONE_IN), .CLEAR(CLEAR),
        .FLAG_OUT(FLAG_OUT), .BUSY(BUSY), .TASK_DONE_OUT(TASK_DONE_OUT), .TIMEOUT(TIMEOUT),
        .OVERFLOW(OVERFLOW), .PENDING(PENDING));

    always #5 CLK = ~CLK;
    assign obs = {FLAG_OUT, BUSY, TASK_DONE_OUT, TIMEOUT, OVERFLOW, PENDING};

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0; m_ovf[c] = 0; m_age[c] = 0; m_pend[c] = 0;
        end
        e_fo = '0; e_tdo = '0; e_tmo = '0;
    endtask

    function automatic logic [AW-1:0] expected();
        logic [CH-1:0] b, o;
        logic [CH*CW-1:0] p;
        for (int c = 0; c < CH; c++) begin
            b[c] = m_run[c];
            o[c] = m_ovf[c];
            p[c*CW +: CW] = CW'(m_pend[c]);
        end
        return {e_fo, b, e_tdo, e_tmo, o, p};
    endfunction

    // one clock: drive inputs, advance the model, sample 1ns after the edge
    task automatic tick(input logic [CH-1:0] f, input logic [CH-1:0] d, input logic clr);
        bit was_end;
        FLAG_IN = f; TASK_DONE_IN = d; CLEAR = clr;
        for (int c = 0; c < CH; c++) begin
            was_end = e_tdo[c] | e_tmo[c];
            e_fo[c] = 0; e_tdo[c] = 0; e_tmo[c] = 0;
            if (clr) m_ovf[c] = 0;
            if (was_end) begin
                if (m_pend[c] > 0 || f[c]) begin
                    m_run[c] = 1; m_age[c] = 0; e_fo[c] = 1;
                    if (!f[c]) m_pend[c]--;
                end
            end else if (m_run[c]) begin
                if (f[c]) begin
                    if (m_pend[c] < DEPTH) m_pend[c]++;
                    else m_ovf[c] = 1;
                end
                if (d[c]) begin m_run[c] = 0; e_tdo[c] = 1; end
                else if (TO_EN && m_age[c] + 1 == TMO) begin m_run[c] = 0; e_tmo[c] = 1; end
                else m_age[c]++;
            end else if (f[c]) begin
                m_run[c] = 1; m_age[c] = 0; e_fo[c] = 1;
            end
        end
        @(posedge CLK); #1;
        FLAG_IN = '0; TASK_DONE_IN = '0; CLEAR = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; model_reset();
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; model_reset(); #1;
        total++; if (obs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick('0, '0, 1'b0);
            total++; if (obs !== expected()) begin bad++; $display("FAIL idle got=%h want=%h", obs, expected()); end
        end
    endtask

    task automatic test_basic();
        tick(4'b0001, '0, 1'b0);
        total++; if ({FLAG_OUT[0], BUSY[0]} !== 2'b11) begin bad++; $display("FAIL basic_start got=%b want=11", {FLAG_OUT[0], BUSY[0]}); end
        repeat (3) begin
            tick('0, '0, 1'b0);
            total++; if (obs !== expected()) begin bad++; $display("FAIL basic_run got=%h want=%h", obs, expected()); end
        end
        tick('0, 4'b0001, 1'b0);
        total++; if ({TASK_DONE_OUT[0], BUSY[0]} !== 2'b10) begin bad++; $display("FAIL basic_done got=%b want=10", {TASK_DONE_OUT[0], BUSY[0]}); end
        tick('0, '0, 1'b0);
        total++; if (obs !== expected()) begin bad++; $display("FAIL basic_idle got=%h want=%h", obs, expected()); end
    endtask

    task automatic test_queue();
        logic [CW:0] want;
        tick(4'b0010, '0, 1'b0);
        repeat (4) tick(4'b0010, '0, 1'b0);
        total++; if ({OVERFLOW[1], PENDING[CW +: CW]} !== {1'b1, CW'(3)}) begin bad++; $display("FAIL queue_full got=%b want=1_11", {OVERFLOW[1], PENDING[CW +: CW]}); end
        for (int k = 0; k < 4; k++) begin
            tick('0, 4'b0010, 1'b0);
            total++; if (TASK_DONE_OUT[1] !== 1'b1) begin bad++; $display("FAIL queue_done%0d got=%b want=1", k, TASK_DONE_OUT[1]); end
            tick('0, '0, 1'b0);
            want = {k < 3, CW'(k < 3 ? 2 - k : 0)};
            total++; if ({FLAG_OUT[1], PENDING[CW +: CW]} !== want) begin bad++; $display("FAIL queue_restart%0d got=%b want=%b", k, {FLAG_OUT[1], PENDING[CW +: CW]}, want); end
        end
        tick('0, '0, 1'b1);
        total++; if (OVERFLOW[1] !== 1'b0) begin bad++; $display("FAIL queue_clear got=%b want=0", OVERFLOW[1]); end
        total++; if (obs !== expected()) begin bad++; $display("FAIL queue_model got=%h want=%h", obs, expected()); end
    endtask

    task automatic test_simultaneous();
        tick(4'b0100, '0, 1'b0);
        tick(4'b0100, '0, 1'b0);
        tick('0, 4'b0100, 1'b0);
        tick(4'b0100, '0, 1'b0);
        total++; if ({FLAG_OUT[2], PENDING[2*CW +: CW]} !== {1'b1, CW'(1)}) begin bad++; $display("FAIL sim_done_flag got=%b want=1_01", {FLAG_OUT[2], PENDING[2*CW +: CW]}); end
        tick(4'b0100, '0, 1'b0);
        tick(4'b0100, '0, 1'b0);
        tick(4'b0100, '0, 1'b1);
        total++; if (OVERFLOW[2] !== 1'b1) begin bad++; $display("FAIL sim_set_wins got=%b want=1", OVERFLOW[2]); end
        tick('0, '0, 1'b1);
        total++; if (OVERFLOW[2] !== 1'b0) begin bad++; $display("FAIL sim_clear got=%b want=0", OVERFLOW[2]); end
        total++; if (obs !== expected()) begin bad++; $display("FAIL sim_model got=%h want=%h", obs, expected()); end
    endtask

    task automatic test_channels(input int n);
        logic [CH-1:0] f, d;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CH; c++) begin
                f[c] = $urandom_range(3) == 0;
                d[c] = $urandom_range(2) == 0;
            end
            tick(f, d, $urandom_range(15) == 0);
            total++; if (obs !== expected()) begin bad++; $display("FAIL rand%0d got=%h want=%h", k, obs, expected()); end
`ifndef TASK_TIMEOUT_EN
            total++; if (TIMEOUT !== '0) begin bad++; $display("FAIL no_timeout%0d got=%b want=0", k, TIMEOUT); end
`endif
        end
        repeat (20) begin
            tick('0, '1, 1'b0);
            total++; if (obs !== expected()) begin bad++; $display("FAIL drain got=%h want=%h", obs, expected()); end
        end
        total++; if ({BUSY, TASK_DONE_OUT} !== '0) begin bad++; $display("FAIL idle_done_ignored got=%b want=0", {BUSY, TASK_DONE_OUT}); end
    endtask

`ifdef TASK_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        tick(4'b1000, '0, 1'b0);
        tick(4'b1000, '0, 1'b0);
        n = 0;
        while (TIMEOUT[3] !== 1'b1 && n < 20) begin
            tick('0, '0, 1'b0);
            n++;
            total++; if (obs !== expected()) begin bad++; $display("FAIL tmo_model got=%h want=%h", obs, expected()); end
        end
        total++; if (n !== TMO - 1) begin bad++; $display("FAIL tmo_latency got=%0d want=%0d", n, TMO - 1); end
        total++; if (TASK_DONE_OUT[3] !== 1'b0) begin bad++; $display("FAIL tmo_no_done got=%b want=0", TASK_DONE_OUT[3]); end
        tick('0, '0, 1'b0);
        total++; if ({FLAG_OUT[3], PENDING[3*CW +: CW]} !== {1'b1, CW'(0)}) begin bad++; $display("FAIL tmo_restart got=%b want=1_00", {FLAG_OUT[3], PENDING[3*CW +: CW]}); end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        repeat (3) tick(4'b0001, '0, 1'b0);
        total++; if (PENDING[0 +: CW] !== CW'(2)) begin bad++; $display("FAIL mid_pending got=%0d want=2", PENDING[0 +: CW]); end
        #2 RST_N = 1'b0; model_reset();
        #1;
        total++; if (obs !== '0) begin bad++; $display("FAIL mid_async got=%h want=0", obs); end
        @(posedge CLK);
        #3 RST_N = 1'b1;
        repeat (5) begin
            tick('0, '0, 1'b0);
            total++; if (obs !== expected() || FLAG_OUT !== '0) begin bad++; $display("FAIL mid_quiet got=%h want=%h", obs, expected()); end
        end
        tick(4'b0001, '0, 1'b0);
        total++; if (FLAG_OUT[0] !== 1'b1) begin bad++; $display("FAIL mid_fresh got=%b want=1", FLAG_OUT[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_queue();
        test_simultaneous();
`ifdef TASK_TIMEOUT_EN
        test_channels(3000);
        test_timeout();
`else
        test_channels(10000);
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
